pipe_skid_stage: RTL and testbench

- Parametrised pipeline stage register for the mips_cpu datapath.
- Generalises the fixed-field stall/flush stage registers: one payload bus of DATA_W bits, a valid/ready handshake on both sides, an optional two-entry skid buffer so in_ready is registered, and synchronous flush.
- Sits between any two pipeline stages (ID/EX, EX/MEM, ...).
- A saturating back-pressure counter supports performance analysis.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/sat_counter.sv | 24 ++
 rtl/pipe_skid_stage.sv | 138 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and widths for pipeline stage registers
package pipe_pkg;

  // Stage occupancy: EMPTY holds nothing, FULL holds main, SKID holds main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  localparam int STALL_CNT_W = 16;

  // Concatenated payload widths of the datapath stage registers.
  localparam int IDEX_W  = 160;
  localparam int EXMEM_W = 107;
  localparam int MEMWB_W = 71;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - valid/ready pipeline stage register with optional skid entry
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W       = IDEX_W,
  parameter int SKID_EN      = 1,
  parameter int CLR_ON_FLUSH = 1,
  parameter int CNT_W        = STALL_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              cnt_clr
);

  pipe_state_e       state;
  pipe_state_e       state_nxt;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_data;
  logic              load_main;
  logic              skid_to_main;
  logic              xfer_in;
  logic              xfer_out;

  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;

  // With the skid entry in_ready is a pure state decode; without it the
  // single register frees up in the same cycle it is consumed.
  assign in_ready = ~rst & ((SKID_EN != 0) ? (state != ST_SKID)
                                           : ((state == ST_EMPTY) | out_ready));

  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = out_valid & out_ready;

  // Next-state and main-register load decisions; flush discards everything held or offered.
  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    skid_to_main = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (xfer_in) begin
          state_nxt = ST_FULL;
          load_main = 1'b1;
        end
      end
      ST_FULL: begin
        if (xfer_in && xfer_out) begin
          load_main = 1'b1;
        end else if (xfer_in && (SKID_EN != 0)) begin
          state_nxt = ST_SKID;
        end else if (xfer_out) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (xfer_out) begin
          state_nxt    = ST_FULL;
          load_main    = 1'b1;
          skid_to_main = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      state_nxt = ST_EMPTY;
      load_main = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Main payload register feeding out_data; refilled from the skid entry when it drains.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      if (CLR_ON_FLUSH != 0) begin
        main_q <= '0;
      end
    end else if (load_main) begin
      main_q <= skid_to_main ? skid_data : in_data;
    end
  end

  generate
    if (SKID_EN != 0) begin : g_skid
      logic [DATA_W-1:0] skid_q;

      // Skid entry captures the word accepted while main is stalled downstream.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          if (CLR_ON_FLUSH != 0) begin
            skid_q <= '0;
          end
        end else if ((state == ST_FULL) && xfer_in && !xfer_out) begin
          skid_q <= in_data;
        end
      end

      assign skid_data = skid_q;
    end else begin : g_no_skid
      assign skid_data = '0;
    end
  endgenerate

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .inc(out_valid & ~out_ready),
    .cnt(stall_cnt)
  );

`ifndef SYNTHESIS
  a_in_data_stable: assert property (@(posedge clk)
    (!rst && !flush && in_valid && !in_ready) |=> (rst || flush || !in_valid || $stable(in_data)));

  a_no_skid_state: assert property (@(posedge clk)
    !((SKID_EN == 0) && (state == ST_SKID)));
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - directed self-checking bench for pipe_skid_stage
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [15:0] in_data;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_valid_a, in_ready_a, out_valid_a;
  logic [15:0] out_data_a, stall_cnt_a;
  logic        in_valid_b, in_ready_b, out_valid_b;
  logic [15:0] out_data_b;
  logic [3:0]  stall_cnt_b;
  logic        in_valid_c, in_ready_c, out_valid_c;
  logic [15:0] out_data_c, stall_cnt_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(16), .SKID_EN(1), .CLR_ON_FLUSH(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .stall_cnt(stall_cnt_a), .cnt_clr(cnt_clr)
  );

  pipe_skid_stage #(.DATA_W(16), .SKID_EN(1), .CLR_ON_FLUSH(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .stall_cnt(stall_cnt_b), .cnt_clr(cnt_clr)
  );

  pipe_skid_stage #(.DATA_W(16), .SKID_EN(0), .CLR_ON_FLUSH(1), .CNT_W(16)) u_nos (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
    .stall_cnt(stall_cnt_c), .cnt_clr(cnt_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_data = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0;

    // Reset state
    next(); next();
    chk("rst_in_ready", 32'(in_ready_a), 0);
    chk("rst_out_valid", 32'(out_valid_a), 0);
    chk("rst_out_data", 32'(out_data_a), 0);
    chk("rst_stall_cnt", 32'(stall_cnt_a), 0);
    rst = 1'b0; settle();
    chk("post_rst_in_ready", 32'(in_ready_a), 1);

    // Back-to-back streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid_a = 1'b1; in_data = 16'(i);
      next();
      chk("stream_valid", 32'(out_valid_a), 1);
      chk("stream_data", 32'(out_data_a), i);
      chk("stream_in_ready", 32'(in_ready_a), 1);
    end
    in_valid_a = 1'b0;
    next();
    chk("stream_drained", 32'(out_valid_a), 0);
    chk("stream_stall_cnt", 32'(stall_cnt_a), 0);

    // Back-pressure into the skid entry
    out_ready = 1'b0;
    in_valid_a = 1'b1; in_data = 16'hAAAA;
    next();
    in_data = 16'hBBBB;
    next();
    in_data = 16'hCCCC; settle();
    chk("skid_in_ready", 32'(in_ready_a), 0);
    chk("skid_out_data", 32'(out_data_a), 32'hAAAA);
    chk("skid_out_valid", 32'(out_valid_a), 1);
    next(); next(); next();
    chk("skid_hold_data", 32'(out_data_a), 32'hAAAA);
    chk("skid_stall_cnt", 32'(stall_cnt_a), 4);
    out_ready = 1'b1; settle();
    chk("drain_a", 32'(out_data_a), 32'hAAAA);
    next();
    chk("drain_b", 32'(out_data_a), 32'hBBBB);
    next();
    chk("drain_c", 32'(out_data_a), 32'hCCCC);
    in_valid_a = 1'b0;
    next();
    chk("drain_empty", 32'(out_valid_a), 0);
    chk("drain_stall_cnt", 32'(stall_cnt_a), 4);

    // Flush while in SKID with a concurrent offer
    out_ready = 1'b0;
    in_valid_a = 1'b1; in_data = 16'h1111;
    next();
    in_data = 16'h2222;
    next();
    in_data = 16'h1234; flush = 1'b1; settle();
    chk("pre_flush_in_ready", 32'(in_ready_a), 0);
    next();
    flush = 1'b0; in_valid_a = 1'b0;
    chk("flush_out_valid", 32'(out_valid_a), 0);
    chk("flush_in_ready", 32'(in_ready_a), 1);
    chk("flush_out_data", 32'(out_data_a), 0);
    chk("flush_stall_cnt", 32'(stall_cnt_a), 6);
    out_ready = 1'b1;
    next(); next();
    chk("flush_no_ghost", 32'(out_valid_a), 0);

    // Saturating counter, CNT_W=4
    out_ready = 1'b0;
    in_valid_b = 1'b1; in_data = 16'h0005;
    next();
    in_valid_b = 1'b0;
    for (int i = 0; i < 20; i++) next();
    chk("sat_cnt", 32'(stall_cnt_b), 15);
    chk("sat_hold_data", 32'(out_data_b), 5);
    cnt_clr = 1'b1;
    next();
    cnt_clr = 1'b0;
    chk("sat_clr", 32'(stall_cnt_b), 0);
    next();
    chk("sat_resume1", 32'(stall_cnt_b), 1);
    next();
    chk("sat_resume2", 32'(stall_cnt_b), 2);

    // Single-register variant
    out_ready = 1'b1; in_valid_c = 1'b1; in_data = 16'h0A0A; settle();
    chk("nos_in_ready_empty", 32'(in_ready_c), 1);
    next();
    chk("nos_out_valid", 32'(out_valid_c), 1);
    chk("nos_data1", 32'(out_data_c), 32'h0A0A);
    in_data = 16'h0B0B; settle();
    chk("nos_in_ready_pass", 32'(in_ready_c), 1);
    next();
    chk("nos_data2", 32'(out_data_c), 32'h0B0B);
    out_ready = 1'b0; in_data = 16'h0C0C; settle();
    chk("nos_in_ready_blocked", 32'(in_ready_c), 0);
    next();
    chk("nos_hold", 32'(out_data_c), 32'h0B0B);
    out_ready = 1'b1; settle();
    chk("nos_in_ready_comb", 32'(in_ready_c), 1);
    next();
    chk("nos_data3", 32'(out_data_c), 32'h0C0C);
    in_valid_c = 1'b0;
    next();
    chk("nos_drained", 32'(out_valid_c), 0);

    // Reset mid-stream with the stage in SKID
    out_ready = 1'b0;
    in_valid_a = 1'b1; in_data = 16'h0007;
    next();
    in_data = 16'h0008;
    next();
    in_valid_a = 1'b0; settle();
    chk("mid_skid_in_ready", 32'(in_ready_a), 0);
    rst = 1'b1; out_ready = 1'b1; settle();
    chk("mid_rst_in_ready", 32'(in_ready_a), 0);
    next();
    chk("mid_rst_out_valid", 32'(out_valid_a), 0);
    chk("mid_rst_stall_cnt", 32'(stall_cnt_a), 0);
    chk("mid_rst_out_data", 32'(out_data_a), 0);
    out_ready = 1'b0;
    next();
    chk("mid_rst_in_ready2", 32'(in_ready_a), 0);
    rst = 1'b0; settle();
    chk("mid_post_in_ready", 32'(in_ready_a), 1);
    chk("mid_post_out_valid", 32'(out_valid_a), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
